mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width (256 words).
REQ-002 The block SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port f_req  input  1  instruction-fetch read request, held until f_gnt.
REQ-006 The block SHALL have ports f_addr  input  ADDR_W, f_gnt  output  1, f_rvalid  output  1 and f_rdata  output  DATA_W, carrying fetch address, grant pulse, read-data-valid pulse and read data.
REQ-007 The block SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  ADDR_W and d_wdata  input  DATA_W, carrying the load/store request, write enable, address and write data.
REQ-008 The block SHALL have ports d_gnt  output  1, d_rvalid  output  1 and d_rdata  output  DATA_W, carrying the data-port grant, read-valid pulse and read data.
REQ-009 The block SHALL have ports mem_en  output  1, mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W and mem_rdata  input  DATA_W, forming the single-port memory unit interface; mem_rdata is valid one cycle after mem_en with mem_we low.
REQ-010 The block SHALL have port arb_busy  output  1, high in every state except IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ACCESS and WAIT.
REQ-012 In IDLE with any request present, the block SHALL pick a winner, register its we/addr/wdata (fetch we=0) and move to ACCESS; otherwise it SHALL stay in IDLE.
REQ-013 In ACCESS, mem_en SHALL be 1, mem_* SHALL come from the latched registers and the winner's gnt SHALL be 1 for exactly this one cycle.
REQ-014 From ACCESS, a write SHALL return to IDLE (no rvalid) and a read SHALL go to WAIT.
REQ-015 In WAIT, the block SHALL load mem_rdata into the winner's rdata register, set that port's rvalid for the next cycle and return to IDLE.
REQ-016 Read latency SHALL be 3 cycles from the req-sampling edge to rvalid; write occupancy SHALL be 2 cycles.
REQ-017 An IDLE cycle in which rvalid is high SHALL still accept a new request.
REQ-018 rvalid SHALL be a one-cycle pulse; rdata SHALL hold its last value until the next read completes on that port.
REQ-019 Requests SHALL be sampled only in IDLE; req or address changes after latching SHALL NOT affect the transaction in flight.
REQ-020 A requester deasserting req before the IDLE sample SHALL be treated as having withdrawn: no grant and no access.
REQ-021 Outside ACCESS, mem_en and mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-022 At most one gnt SHALL be high in any cycle.

Reset
REQ-023 On rst low, the FSM SHALL go to IDLE immediately and all gnt, rvalid, mem_en, mem_we and arb_busy SHALL be 0, all rdata, mem_addr and mem_wdata SHALL be 0, and the priority pointer SHALL point to data.
REQ-024 Reset asserted in ACCESS or WAIT SHALL abort the transaction with no rvalid, and no access SHALL be replayed after reset release.

Configuration
REQ-025 With ROUND_ROBIN_EN defined, simultaneous requests SHALL be served by an alternating pointer that flips to the other port after each grant, and the pointer SHALL NOT move when only one port requests.
REQ-026 Without ROUND_ROBIN_EN, simultaneous requests SHALL use fixed priority with data over fetch, and no pointer register SHALL exist.

Structure
REQ-027 ADDR_W/DATA_W defaults, the state encoding (IDLE=0, ACCESS=1, WAIT=2) and the port-ID constants (PORT_F, PORT_D) SHALL live in the shared risc_pkg package.
REQ-028 The grant decision SHALL be a sub-module, mem_arb_pick, taking f_req, d_req and the pointer and returning a one-hot winner; the FSM SHALL stay in mem_arbiter.

Verification
REQ-029 The bench SHALL cover: fetch-only read f_addr=0x10, memory[0x10]=0xA5A5 -> f_gnt at T+1, mem_en at T+1, f_rvalid=1 with f_rdata=0xA5A5 at T+3.
REQ-030 The bench SHALL cover: data write d_we=1, d_addr=0xCB, d_wdata=0x1234 -> mem_we=1 for one cycle, no d_rvalid, arb_busy low at T+2; a following read of 0xCB returns 0x1234.
REQ-031 The bench SHALL cover: f_req and d_req high together, held for 4 transactions -> without the macro, all d grants before any f grant; with ROUND_ROBIN_EN, grant order d,f,d,f.
REQ-032 The bench SHALL cover: f_addr changed from 0x20 to 0x30 during ACCESS -> mem_addr stays 0x20 and f_rdata = memory[0x20].
REQ-033 The bench SHALL cover: rst pulsed low during WAIT of a d read -> d_rvalid never asserted, all outputs 0, and a new f read after release completes normally.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the memory arbiter: width defaults, FSM state encoding
// and requester port IDs used by mem_arbiter and mem_arb_pick.
package risc_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_F = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: one-hot winner (bit index = port ID) from the two requests;
// on a tie the port named by ptr wins.
module mem_arb_pick
    import risc_pkg::*;
(
    input  logic       f_req,
    input  logic       d_req,
    input  logic       ptr,
    output logic [1:0] win
);

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        win = 2'b00;
        if (f_req && d_req) begin
            win[ptr] = 1'b1;
        end else if (d_req) begin
            win[PORT_D] = 1'b1;
        end else if (f_req) begin
            win[PORT_F] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory unit.
// Define ROUND_ROBIN_EN for alternating tie-break; default is data-over-fetch.
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              arb_busy
);

    arb_state_t        state;
    arb_state_t        state_nxt;

    port_id_t          win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        win;
    port_id_t          win_id;
    port_id_t          ptr;
    logic              accept;

    assign win_id = win[PORT_D] ? PORT_D : PORT_F;
    assign accept = (state == IDLE) && (|win);

`ifdef ROUND_ROBIN_EN
    port_id_t ptr_q;

    // Only a genuine tie moves the pointer; a lone requester leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PORT_D;
        end else if (accept && f_req && d_req) begin
            ptr_q <= other_port(win_id);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = PORT_D;
`endif

    mem_arb_pick u_pick (
        .f_req (f_req),
        .d_req (d_req),
        .ptr   (ptr),
        .win   (win)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (|win) ? ACCESS : IDLE;
            ACCESS:  state_nxt = we_q ? IDLE : WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction is frozen here at the IDLE sample; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q   <= PORT_F;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            win_q <= win_id;
            if (win_id == PORT_D) begin
                we_q    <= d_we;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end else begin
                we_q   <= 1'b0;
                addr_q <= f_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (state == WAIT) begin
                if (win_q == PORT_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= mem_rdata;
                end else begin
                    f_rvalid <= 1'b1;
                    f_rdata  <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        arb_busy = (state != IDLE);
        mem_en   = (state == ACCESS);
        mem_we   = (state == ACCESS) && we_q;
        f_gnt    = (state == ACCESS) && (win_q == PORT_F);
        d_gnt    = (state == ACCESS) && (win_q == PORT_D);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [7:0]  f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        arb_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_array [256];
    logic [15:0] ref_mem   [256];
    logic [15:0] last_f;
    logic [15:0] last_d;
    logic        model_ptr_d;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory unit: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_ctrl", 32'({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, arb_busy}), 32'd0);
        check("rst_f_rdata", 32'(f_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        check("rst_hold_rvalid", 32'({f_rvalid, d_rvalid}), 32'd0);
        @(negedge clk);
        rst         = 1'b1;
        last_f      = 16'h0;
        last_d      = 16'h0;
        model_ptr_d = 1'b1;
    endtask

    // Called at the negedge just before the IDLE sampling edge, with the
    // requester's inputs already driven.
    task automatic check_txn(input logic is_d, input logic we, input logic [7:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rdata,
                             input logic scramble);
        @(negedge clk);
        check("gnt_f", 32'(f_gnt), 32'(!is_d));
        check("gnt_d", 32'(d_gnt), 32'(is_d));
        check("mem_en_access", 32'(mem_en), 32'd1);
        check("mem_we_access", 32'(mem_we), 32'(we));
        check("mem_addr_access", 32'(mem_addr), 32'(addr));
        if (we) check("mem_wdata_access", 32'(mem_wdata), 32'(wdata));
        check("busy_access", 32'(arb_busy), 32'd1);
        check("rvalid_access", 32'({f_rvalid, d_rvalid}), 32'd0);
        if (scramble) begin
            if (is_d) begin
                d_req  = 1'b0;
                d_addr = d_addr ^ 8'h10;
            end else begin
                f_req  = 1'b0;
                f_addr = f_addr ^ 8'h10;
            end
        end
        @(negedge clk);
        check("gnt_after", 32'({f_gnt, d_gnt}), 32'd0);
        check("mem_en_after", 32'({mem_en, mem_we}), 32'd0);
        check("mem_addr_hold", 32'(mem_addr), 32'(addr));
        check("busy_after", 32'(arb_busy), 32'(!we));
        check("rvalid_after", 32'({f_rvalid, d_rvalid}), 32'd0);
        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            @(negedge clk);
            check("busy_rvalid", 32'(arb_busy), 32'd0);
            check("f_rvalid", 32'(f_rvalid), 32'(!is_d));
            check("d_rvalid", 32'(d_rvalid), 32'(is_d));
            if (is_d) last_d = exp_rdata;
            else      last_f = exp_rdata;
            check("f_rdata", 32'(f_rdata), 32'(last_f));
            check("d_rdata", 32'(d_rdata), 32'(last_d));
        end
    endtask

    task automatic drive_vec(input vec_t v);
        f_req = !v.is_d;
        d_req = v.is_d;
        if (v.is_d) begin
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            f_addr = v.addr;
        end
    endtask

    initial begin
        logic [3:0] order;
        logic       win_d;

        f_req = 1'b0; f_addr = 8'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h0; d_wdata = 16'h0;
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = {8'(i), ~8'(i)};
            ref_mem[i]   = {8'(i), ~8'(i)};
        end
        mem_array[8'h10] = 16'hA5A5;
        ref_mem[8'h10]   = 16'hA5A5;

        vecs[0]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
        vecs[1]  = '{1'b1, 1'b1, 8'hCB, 16'h1234, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 8'hCB, 16'h0000, 16'h1234};
        vecs[3]  = '{1'b0, 1'b0, 8'hCB, 16'h0000, 16'h1234};
        vecs[4]  = '{1'b1, 1'b1, 8'h00, 16'hBEEF, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'hBEEF};
        vecs[6]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
        vecs[7]  = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h20DF};
        vecs[8]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hFF00};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};

        do_reset();

        // Directed single-requester table, issued back to back.
        for (int i = 0; i < 11; i++) begin
            drive_vec(vecs[i]);
            check_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b1);
        end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("idle_after_table", 32'({arb_busy, mem_en, f_rvalid, d_rvalid}), 32'd0);

        // Both ports requesting continuously for four transactions.
        do_reset();
`ifdef ROUND_ROBIN_EN
        order = 4'b0101;
`else
        order = 4'b1111;
`endif
        f_req = 1'b1; f_addr = 8'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'hCB;
        for (int i = 0; i < 4; i++) begin
            check_txn(order[i], 1'b0, order[i] ? 8'hCB : 8'h10, 16'h0,
                      order[i] ? 16'h1234 : 16'hA5A5, 1'b0);
        end
        d_req = 1'b0;
`ifndef ROUND_ROBIN_EN
        check_txn(1'b0, 1'b0, 8'h10, 16'h0, 16'hA5A5, 1'b1);
`endif
        f_req = 1'b0;

        // Fetch address moves from 0x20 to 0x30 while the access is in flight.
        f_req = 1'b1; f_addr = 8'h20;
        check_txn(1'b0, 1'b0, 8'h20, 16'h0, 16'h20DF, 1'b1);
        check("addr_moved_in_access", 32'(f_addr), 32'h30);

        // Fetch raises req during a write and withdraws before the IDLE sample.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h50; d_wdata = 16'h5555;
        @(negedge clk);
        check("wd_d_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0; f_req = 1'b1; f_addr = 8'h60;
        @(negedge clk);
        check("wd_idle", 32'(arb_busy), 32'd0);
        f_req = 1'b0;
        @(negedge clk);
        check("wd_no_grant", 32'({f_gnt, d_gnt, mem_en, arb_busy}), 32'd0);
        ref_mem[8'h50] = 16'h5555;

        // Reset lands in WAIT of a data read.
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
        @(negedge clk);
        check("r33_d_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        @(negedge clk);
        check("r33_busy_wait", 32'(arb_busy), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r33_no_replay", 32'({d_rvalid, f_rvalid, mem_en, arb_busy}), 32'd0);
        end
        f_req = 1'b1; f_addr = 8'h20;
        check_txn(1'b0, 1'b0, 8'h20, 16'h0, 16'h20DF, 1'b1);

        // Randomized traffic against the transaction-level model.
        for (int n = 0; n < 400; n++) begin
            if (!f_req && $urandom_range(0, 2) != 0) begin
                f_req  = 1'b1;
                f_addr = 8'($urandom_range(240, 255));
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 8'($urandom_range(240, 255));
                d_wdata = 16'($urandom);
            end
            if (f_req && d_req) begin
`ifdef ROUND_ROBIN_EN
                win_d       = model_ptr_d;
                model_ptr_d = !win_d;
`else
                win_d = 1'b1;
`endif
            end else begin
                win_d = d_req;
            end
            if (!f_req && !d_req) begin
                @(negedge clk);
                check("rand_idle", 32'({arb_busy, mem_en, f_gnt, d_gnt, f_rvalid, d_rvalid}), 32'd0);
            end else if (win_d) begin
                check_txn(1'b1, d_we, d_addr, d_wdata, ref_mem[d_addr], 1'b1);
            end else begin
                check_txn(1'b0, 1'b0, f_addr, 16'h0, ref_mem[f_addr], 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
